// File: rtl/onchip_flash_programmer.sv
// Avalon-MM master for the on-chip flash IP: unprotects and erases one sector,
// programs a stream of 32-bit words into it, then re-protects the sector.
// The CSR status register is polled after every erase and every word write.
module onchip_flash_programmer #(
  parameter int          ADDR_W         = 17,
  parameter int          CNT_W          = 17,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd12000000
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [2:0]        sector_sel,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [CNT_W-1:0]  word_count,
  input  logic [31:0]       din_data,
  input  logic              din_valid,
  output logic              din_ready,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [1:0]        err_code,
  output logic [ADDR_W-1:0] avmm_data_addr,
  output logic              avmm_data_write,
  output logic [31:0]       avmm_data_writedata,
  output logic              avmm_data_read,
  output logic [3:0]        avmm_data_burstcount,
  input  logic              avmm_data_waitrequest,
  output logic              avmm_csr_addr,
  output logic              avmm_csr_read,
  output logic              avmm_csr_write,
  output logic [31:0]       avmm_csr_writedata,
  input  logic [31:0]       avmm_csr_readdata
);

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_UNPROT    = 4'd1;
  localparam logic [3:0] S_ERASE     = 4'd2;
  localparam logic [3:0] S_E_POLL    = 4'd3;
  localparam logic [3:0] S_NEXT_WORD = 4'd4;
  localparam logic [3:0] S_WR        = 4'd5;
  localparam logic [3:0] S_W_POLL    = 4'd6;
  localparam logic [3:0] S_PROT      = 4'd7;
  localparam logic [3:0] S_FINISH    = 4'd8;

  localparam logic [1:0] ERR_NONE   = 2'd0;
  localparam logic [1:0] ERR_SECTOR = 2'd1;
  localparam logic [1:0] ERR_ERASE  = 2'd2;
  localparam logic [1:0] ERR_WRITE  = 2'd3;

  localparam logic [19:0] PAGE_ALL = 20'hFFFFF;

  logic [3:0]        state_q, state_d;
  logic [2:0]        sector_q, sector_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [23:0]       tmo_q, tmo_d;
  logic              phase_q, phase_d;   // 0: issue status read, 1: evaluate readdata
  logic [1:0]        err_q, err_d;
  logic              error_q, error_d;

  logic [4:0]        wp_unprot;
  logic              stat_busy;
  logic              unused_readdata;

  assign wp_unprot = 5'h1F & ~(5'b00001 << (sector_q - 3'd1));
  assign stat_busy = (avmm_csr_readdata[1:0] != 2'b00);
  assign unused_readdata = &{1'b0, avmm_csr_readdata[31:5], avmm_csr_readdata[2]};

  // Next-state logic for the sequencer and its datapath registers.
  always_comb begin
    // NOTE: every variable gets a default first so no path infers a latch.
    state_d  = state_q;
    sector_d = sector_q;
    addr_d   = addr_q;
    count_d  = count_q;
    wdata_d  = wdata_q;
    tmo_d    = tmo_q;
    phase_d  = phase_q;
    err_d    = err_q;
    error_d  = error_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          sector_d = sector_sel;
          addr_d   = start_addr;
          count_d  = word_count;
          err_d    = ERR_NONE;
          error_d  = 1'b0;
          if (sector_sel == 3'd0 || sector_sel > 3'd5) begin
            err_d   = ERR_SECTOR;
            error_d = 1'b1;
            state_d = S_FINISH;
          end else begin
            state_d = S_UNPROT;
          end
        end
      end
      S_UNPROT: state_d = S_ERASE;
      S_ERASE: begin
        tmo_d   = '0;
        phase_d = 1'b0;
        state_d = S_E_POLL;
      end
      S_E_POLL, S_W_POLL: begin
        tmo_d = tmo_q + 24'd1;
        if (!phase_q) begin
          phase_d = 1'b1;
        end else begin
          phase_d = 1'b0;
          if (stat_busy) begin
            if (tmo_q >= TIMEOUT_CYCLES) begin
              err_d   = (state_q == S_E_POLL) ? ERR_ERASE : ERR_WRITE;
              state_d = S_PROT;
            end
          end else if (state_q == S_E_POLL) begin
            if (avmm_csr_readdata[4]) begin
              state_d = S_NEXT_WORD;
            end else begin
              err_d   = ERR_ERASE;
              state_d = S_PROT;
            end
          end else begin
            if (avmm_csr_readdata[3]) begin
              addr_d  = addr_q + 1'b1;
              count_d = count_q - 1'b1;
              state_d = S_NEXT_WORD;
            end else begin
              err_d   = ERR_WRITE;
              state_d = S_PROT;
            end
          end
        end
      end
      S_NEXT_WORD: begin
        if (count_q == '0) begin
          state_d = S_PROT;
        end else if (din_valid) begin
          wdata_d = din_data;
          state_d = S_WR;
        end
      end
      S_WR: begin
        if (!avmm_data_waitrequest) begin
          tmo_d   = '0;
          phase_d = 1'b0;
          state_d = S_W_POLL;
        end
      end
      S_PROT: begin
        error_d = (err_q != ERR_NONE);
        state_d = S_FINISH;
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // State registers with synchronous active-low reset; reset aborts any operation.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!reset_n) begin
      state_q  <= S_IDLE;
      sector_q <= '0;
      addr_q   <= '0;
      count_q  <= '0;
      wdata_q  <= '0;
      tmo_q    <= '0;
      phase_q  <= 1'b0;
      err_q    <= ERR_NONE;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      sector_q <= sector_d;
      addr_q   <= addr_d;
      count_q  <= count_d;
      wdata_q  <= wdata_d;
      tmo_q    <= tmo_d;
      phase_q  <= phase_d;
      err_q    <= err_d;
      error_q  <= error_d;
    end
  end

  // CSR control word for the current write state: unprotect, erase or protect.
  always_comb begin
    avmm_csr_writedata = '0;
    case (state_q)
      S_UNPROT: avmm_csr_writedata = {4'hF, wp_unprot, 3'b111, PAGE_ALL};
      S_ERASE:  avmm_csr_writedata = {4'hF, wp_unprot, sector_q, PAGE_ALL};
      S_PROT:   avmm_csr_writedata = {4'hF, 5'h1F, 3'b111, PAGE_ALL};
      default:  avmm_csr_writedata = '0;
    endcase
  end

  // Strobes are decoded from the state, so at most one bus strobe is ever high.
  assign avmm_csr_write       = (state_q == S_UNPROT) || (state_q == S_ERASE) || (state_q == S_PROT);
  assign avmm_csr_read        = ((state_q == S_E_POLL) || (state_q == S_W_POLL)) && !phase_q;
  assign avmm_csr_addr        = avmm_csr_write;
  assign avmm_data_write      = (state_q == S_WR);
  assign avmm_data_addr       = addr_q;
  assign avmm_data_writedata  = wdata_q;
  assign avmm_data_read       = 1'b0;
  assign avmm_data_burstcount = 4'd1;
  assign din_ready            = (state_q == S_NEXT_WORD) && (count_q != '0);
  assign busy                 = (state_q != S_IDLE) && (state_q != S_FINISH);
  assign done                 = (state_q == S_FINISH);
  assign error                = error_q;
  assign err_code             = err_q;

endmodule

// File: tb/tb_onchip_flash_programmer.sv
// Directed bench for onchip_flash_programmer with a small behavioural flash model
// that logs every CSR write and every accepted data write.
module tb_onchip_flash_programmer;

  localparam int ADDR_W = 17;
  localparam int CNT_W  = 17;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic [2:0]        sector_sel = '0;
  logic [ADDR_W-1:0] start_addr = '0;
  logic [CNT_W-1:0]  word_count = '0;
  logic [31:0]       din_data = '0;
  logic              din_valid = 1'b0;
  logic              din_ready, busy, done, error;
  logic [1:0]        err_code;
  logic [ADDR_W-1:0] avmm_data_addr;
  logic              avmm_data_write, avmm_data_read;
  logic [31:0]       avmm_data_writedata;
  logic [3:0]        avmm_data_burstcount;
  logic              avmm_data_waitrequest;
  logic              avmm_csr_addr, avmm_csr_read, avmm_csr_write;
  logic [31:0]       avmm_csr_writedata;
  logic [31:0]       avmm_csr_readdata = '0;

  onchip_flash_programmer #(
    .ADDR_W(ADDR_W), .CNT_W(CNT_W), .TIMEOUT_CYCLES(24'd100)
  ) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .sector_sel(sector_sel),
    .start_addr(start_addr), .word_count(word_count), .din_data(din_data),
    .din_valid(din_valid), .din_ready(din_ready), .busy(busy), .done(done),
    .error(error), .err_code(err_code), .avmm_data_addr(avmm_data_addr),
    .avmm_data_write(avmm_data_write), .avmm_data_writedata(avmm_data_writedata),
    .avmm_data_read(avmm_data_read), .avmm_data_burstcount(avmm_data_burstcount),
    .avmm_data_waitrequest(avmm_data_waitrequest), .avmm_csr_addr(avmm_csr_addr),
    .avmm_csr_read(avmm_csr_read), .avmm_csr_write(avmm_csr_write),
    .avmm_csr_writedata(avmm_csr_writedata), .avmm_csr_readdata(avmm_csr_readdata)
  );

  always #5 clock = ~clock;

  // ---------------- flash model configuration (written by the test) ----------------
  int cfg_ebusy = 0, cfg_wbusy = 0, cfg_stall_n = 0, stall_idx = -1;
  bit cfg_eok = 1'b1, cfg_estuck = 1'b0, cfg_wok = 1'b1, cfg_wstuck = 1'b0;

  // ---------------- flash model state and logs ----------------
  int fbusy = 0, wait_cnt = 0, widx = 0;
  bit e_ok = 1'b0, w_ok = 1'b0;
  int wcyc_total = 0, unstable = 0, multi = 0, dready_cyc = 0, din_acc = 0;
  logic [ADDR_W-1:0] hold_addr = '0;
  logic [31:0]       hold_data = '0;
  logic [31:0]       csr_log[$];
  logic [ADDR_W-1:0] wr_addr_log[$];
  logic [31:0]       wr_data_log[$];

  assign avmm_data_waitrequest = avmm_data_write &&
                                 (wait_cnt < ((widx == stall_idx) ? cfg_stall_n : 0));

  always @(posedge clock) begin
    if (int'(avmm_data_write) + int'(avmm_csr_read) + int'(avmm_csr_write) > 1) multi <= multi + 1;
    if (din_ready) dready_cyc <= dready_cyc + 1;
    if (din_ready && din_valid) din_acc <= din_acc + 1;
    if (avmm_csr_write) begin
      csr_log.push_back(avmm_csr_writedata);
      if (avmm_csr_writedata[22:20] != 3'b111) begin
        fbusy <= cfg_estuck ? 1000000 : cfg_ebusy;
        e_ok  <= cfg_eok;
      end
    end else if (avmm_data_write && !avmm_data_waitrequest) begin
      fbusy <= cfg_wstuck ? 1000000 : cfg_wbusy;
      w_ok  <= cfg_wok;
    end else if (fbusy > 0) begin
      fbusy <= fbusy - 1;
    end
    if (avmm_csr_read)
      avmm_csr_readdata <= (fbusy > 0) ? 32'h1 : {27'd0, e_ok, w_ok, 3'd0};
    if (avmm_data_write) begin
      wcyc_total <= wcyc_total + 1;
      if (wait_cnt == 0) begin
        hold_addr <= avmm_data_addr;
        hold_data <= avmm_data_writedata;
      end else if (hold_addr != avmm_data_addr || hold_data != avmm_data_writedata) begin
        unstable <= unstable + 1;
      end
      if (!avmm_data_waitrequest) begin
        wr_addr_log.push_back(avmm_data_addr);
        wr_data_log.push_back(avmm_data_writedata);
        wait_cnt <= 0;
        widx     <= widx + 1;
      end else begin
        wait_cnt <= wait_cnt + 1;
      end
    end
  end

  // ---------------- checking ----------------
  int n_vec = 0;
  int n_miss = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [2:0]        sect;
    logic [ADDR_W-1:0] addr;
    logic [CNT_W-1:0]  cnt;
    int                ebusy;
    bit                eok;
    bit                estuck;
    int                wbusy;
    bit                wok;
    bit                wstuck;
    int                stall_n;
    logic [1:0]        exp_err;
    logic [31:0]       exp_unprot;
    logic [31:0]       exp_erase;
    int                exp_ncsr;
    int                exp_nwr;
  } vec_t;

  localparam int NV = 10;
  vec_t tbl[NV];

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_error"}, {31'd0, error}, 32'd0);
    check({tag, "_err_code"}, {30'd0, err_code}, 32'd0);
    check({tag, "_din_ready"}, {31'd0, din_ready}, 32'd0);
    check({tag, "_strobes"}, {29'd0, avmm_data_write, avmm_csr_read, avmm_csr_write}, 32'd0);
    check({tag, "_data_addr"}, {15'd0, avmm_data_addr}, 32'd0);
    check({tag, "_writedata"}, avmm_data_writedata, 32'd0);
    check({tag, "_csr_writedata"}, avmm_csr_writedata, 32'd0);
    check({tag, "_tied"}, {27'd0, avmm_data_read, avmm_data_burstcount}, 32'd1);
  endtask

  // Launch one operation and wait (bounded) for done, then check everything logged.
  task automatic run_op(input int k, input vec_t v);
    int csr_b, wr_b, wcyc_b, unst_b, dr_b, acc_b, lat;
    bit seen;
    string t;
    t = $sformatf("v%0d", k);
    cfg_ebusy = v.ebusy; cfg_eok = v.eok; cfg_estuck = v.estuck;
    cfg_wbusy = v.wbusy; cfg_wok = v.wok; cfg_wstuck = v.wstuck;
    cfg_stall_n = v.stall_n;
    stall_idx = (v.stall_n > 0) ? widx + 1 : -1;
    csr_b = csr_log.size(); wr_b = wr_addr_log.size();
    wcyc_b = wcyc_total; unst_b = unstable; dr_b = dready_cyc; acc_b = din_acc;
    sector_sel = v.sect; start_addr = v.addr; word_count = v.cnt;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    seen = 1'b0; lat = 0;
    for (int i = 0; i < 5000; i++) begin
      if (done) begin seen = 1'b1; lat = i; break; end
      din_valid = 1'b1;
      din_data  = 32'hA5A5_0001 + 32'(din_acc - acc_b);
      @(negedge clock);
    end
    din_valid = 1'b0;
    check({t, "_done_seen"}, {31'd0, seen}, 32'd1);
    check({t, "_err_code"}, {30'd0, err_code}, {30'd0, v.exp_err});
    check({t, "_error"}, {31'd0, error}, {31'd0, v.exp_err != 2'd0});
    check({t, "_busy_at_done"}, {31'd0, busy}, 32'd0);
    if (v.exp_err == 2'd1) check({t, "_illegal_latency"}, lat, 32'd0);
    @(negedge clock);
    check({t, "_done_one_cycle"}, {31'd0, done}, 32'd0);
    check({t, "_error_sticky"}, {31'd0, error}, {31'd0, v.exp_err != 2'd0});
    check({t, "_n_csr_wr"}, csr_log.size() - csr_b, v.exp_ncsr);
    if (v.exp_ncsr == 3 && csr_log.size() - csr_b == 3) begin
      check({t, "_unprot_word"}, csr_log[csr_b], v.exp_unprot);
      check({t, "_erase_word"}, csr_log[csr_b + 1], v.exp_erase);
      check({t, "_prot_word"}, csr_log[csr_b + 2], 32'hFFFF_FFFF);
    end
    check({t, "_n_data_wr"}, wr_addr_log.size() - wr_b, v.exp_nwr);
    if (wr_addr_log.size() - wr_b == v.exp_nwr) begin
      for (int i = 0; i < v.exp_nwr; i++) begin
        logic [ADDR_W-1:0] ea;
        ea = v.addr + ADDR_W'(i);
        check($sformatf("%s_addr%0d", t, i), {15'd0, wr_addr_log[wr_b + i]}, {15'd0, ea});
        check($sformatf("%s_data%0d", t, i), wr_data_log[wr_b + i], 32'hA5A5_0001 + 32'(i));
      end
    end
    check({t, "_din_accepted"}, din_acc - acc_b, v.exp_nwr);
    if (v.exp_nwr == 0) check({t, "_din_ready_cycles"}, dready_cyc - dr_b, 32'd0);
    check({t, "_write_cycles"}, wcyc_total - wcyc_b, v.exp_nwr + v.stall_n);
    check({t, "_addr_data_stable"}, unstable - unst_b, 32'd0);
  endtask

  initial begin
    int csr_b, wr_b;
    bit seen;
    //           sect addr       cnt ebusy eok estk wbusy wok wstk stall err unprot        erase         ncsr nwr
    tbl[0] = '{3'd2, 17'h04000, 17'd3, 20, 1, 0, 4, 1, 0, 0, 2'd0, 32'hFEFF_FFFF, 32'hFEAF_FFFF, 3, 3};
    tbl[1] = '{3'd0, 17'h00100, 17'd2,  5, 1, 0, 2, 1, 0, 0, 2'd1, 32'h0,         32'h0,         0, 0};
    tbl[2] = '{3'd3, 17'h00200, 17'd2,  6, 0, 0, 2, 1, 0, 0, 2'd2, 32'hFDFF_FFFF, 32'hFDBF_FFFF, 3, 0};
    tbl[3] = '{3'd5, 17'h00300, 17'd2,  3, 1, 0, 2, 1, 1, 0, 2'd3, 32'hF7FF_FFFF, 32'hF7DF_FFFF, 3, 1};
    tbl[4] = '{3'd1, 17'h00400, 17'd0,  3, 1, 0, 2, 1, 0, 0, 2'd0, 32'hFF7F_FFFF, 32'hFF1F_FFFF, 3, 0};
    tbl[5] = '{3'd4, 17'h1FFFF, 17'd2,  2, 1, 0, 1, 1, 0, 0, 2'd0, 32'hFBFF_FFFF, 32'hFBCF_FFFF, 3, 2};
    tbl[6] = '{3'd2, 17'h04100, 17'd3,  4, 1, 0, 3, 1, 0, 7, 2'd0, 32'hFEFF_FFFF, 32'hFEAF_FFFF, 3, 3};
    tbl[7] = '{3'd2, 17'h04200, 17'd1,  0, 0, 1, 0, 1, 0, 0, 2'd2, 32'hFEFF_FFFF, 32'hFEAF_FFFF, 3, 0};
    tbl[8] = '{3'd7, 17'h00500, 17'd1,  1, 1, 0, 1, 1, 0, 0, 2'd1, 32'h0,         32'h0,         0, 0};
    tbl[9] = '{3'd4, 17'h00600, 17'd2,  1, 1, 0, 1, 0, 0, 0, 2'd3, 32'hFBFF_FFFF, 32'hFBCF_FFFF, 3, 1};

    // Reset state.
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    check_reset_outputs("reset");

    // Start ignored while busy: pulse start again mid-operation on the first vector.
    fork
      begin
        repeat (3) @(negedge clock);
        start = 1'b1;
        sector_sel = 3'd0;
        @(negedge clock);
        start = 1'b0;
      end
    join_none

    for (int k = 0; k < NV; k++) run_op(k, tbl[k]);

    // Reset for one cycle during W_POLL aborts with no protect write.
    cfg_ebusy = 2; cfg_eok = 1'b1; cfg_estuck = 1'b0;
    cfg_wbusy = 0; cfg_wok = 1'b1; cfg_wstuck = 1'b1; cfg_stall_n = 0; stall_idx = -1;
    csr_b = csr_log.size(); wr_b = wr_addr_log.size();
    sector_sel = 3'd2; start_addr = 17'h04300; word_count = 17'd2;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    din_valid = 1'b1; din_data = 32'h1234_5678;
    seen = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (wr_addr_log.size() > wr_b) begin seen = 1'b1; break; end
      @(negedge clock);
    end
    din_valid = 1'b0;
    check("rstmid_write_seen", {31'd0, seen}, 32'd1);
    repeat (3) @(negedge clock);
    check("rstmid_busy_before", {31'd0, busy}, 32'd1);
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    check_reset_outputs("rstmid");
    repeat (3) @(negedge clock);
    check("rstmid_no_protect", csr_log.size() - csr_b, 32'd2);

    // A fresh operation after the abort runs normally.
    run_op(100, tbl[0]);

    check("one_strobe_at_a_time", multi, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
